// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, reset/NOP defaults, instruction memory size,
// and the IF/ID pipeline register payload.
// Imported by the fetch stage, its interface and the pipeline register.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int    IMEM_DEPTH_DEFAULT = 64;
    // sll $0,$0,0 -- the canonical MIPS bubble
    localparam word_t NOP_INSTR_DEFAULT  = 32'h0000_0000;

    // Payload carried from fetch into decode
    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc4;
        logic  valid;
    } if_id_t;

    // Byte address -> word index into the instruction memory
    function automatic word_t word_index(input word_t byte_addr);
        return {2'b00, byte_addr[XLEN-1:2]};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: control from later stages, instruction memory link, IF/ID outputs.
// master = fetch stage (drives PC/memory address/IF/ID/errors).
// slave  = surroundings (drive stall/redirect and the memory read data).
interface instruction_fetch_stage_if;
    import cpu_pkg::*;

    logic   stall;
    logic   redirect;
    word_t  redirect_target;
    word_t  imem_addr;
    word_t  imem_data;
    word_t  fetch_pc;
    if_id_t if_id;
    logic   range_err;
    logic   misalign_err;

    modport master (
        input  stall, redirect, redirect_target, imem_data,
        output imem_addr, fetch_pc, if_id, range_err, misalign_err
    );

    modport slave (
        output stall, redirect, redirect_target, imem_data,
        input  imem_addr, fetch_pc, if_id, range_err, misalign_err
    );

endinterface

// File: rtl/if_id_pipe_reg.sv
// Pipeline register between fetch and decode holding instr/pc/pc4/valid.
// Latency 1 cycle; priority flush > hold > load.
// No backpressure of its own: hold freezes contents, flush inserts a bubble.
// Ports: clk, rst (async, active high), load/flush/hold controls, d in, q out.
module if_id_pipe_reg
    import cpu_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.instr <= NOP_INSTR;
            q.pc    <= '0;
            q.pc4   <= '0;
            q.valid <= 1'b0;
        end else if (flush) begin
            // Bubble in: PC/PC4 deliberately left as they were
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: owns the PC, addresses the combinational imem, fills IF/ID.
// Latency: fetch-to-IF/ID 1 cycle (memory read is same-cycle).
// Backpressure: stall freezes PC and IF/ID; redirect wins over stall and flushes IF/ID.
// Ports: clk, rst (async, active high), bus (instruction_fetch_stage_if.master).
module instruction_fetch_stage
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int    IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter word_t NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_stage_if.master bus
);

    word_t  pc;
    word_t  pc_plus4;
    logic   range_err;
    logic   misalign_err;
    logic   advance;
    if_id_t if_id_d;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 -> 0
    assign pc_plus4  = pc + 32'd4;
    assign range_err = (word_index(pc) >= word_t'(IMEM_DEPTH));
    assign advance   = !bus.redirect && !bus.stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.redirect) begin
            // Force word alignment; a misaligned target is flagged, not trapped
            pc <= bus.redirect_target & ~word_t'(3);
        end else if (!bus.stall) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (bus.redirect && (bus.redirect_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

    // Out-of-range fetches still advance and record their PC, but the memory
    // word is not trusted, so a bubble is captured instead.
    always_comb begin
        if_id_d.instr = range_err ? NOP_INSTR : bus.imem_data;
        if_id_d.pc    = pc;
        if_id_d.pc4   = pc_plus4;
        if_id_d.valid = !range_err;
    end

    if_id_pipe_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (advance),
        .flush (bus.redirect),
        .hold  (bus.stall),
        .d     (if_id_d),
        .q     (bus.if_id)
    );

    assign bus.imem_addr    = word_index(pc);
    assign bus.fetch_pc     = pc;
    assign bus.range_err    = range_err;
    assign bus.misalign_err = misalign_err;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_stage_if bus ();

    instruction_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    word_t mem [64];

    // Combinational memory; out-of-range reads return junk the DUT must ignore
    assign bus.imem_data = (bus.imem_addr < 32'd64) ? mem[bus.imem_addr[5:0]] : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state only
    word_t m_pc, m_instr, m_ipc, m_ipc4;
    logic  m_valid, m_mis;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fetch_pc"},  bus.fetch_pc,        m_pc);
        chk({tag, ".imem_addr"}, bus.imem_addr,       m_pc / 4);
        chk({tag, ".instr"},     bus.if_id.instr,     m_instr);
        chk({tag, ".if_pc"},     bus.if_id.pc,        m_ipc);
        chk({tag, ".if_pc4"},    bus.if_id.pc4,       m_ipc4);
        chk({tag, ".valid"},     32'(bus.if_id.valid), 32'(m_valid));
        chk({tag, ".range"},     32'(bus.range_err),  32'((m_pc / 4) >= 64));
        chk({tag, ".misalign"},  32'(bus.misalign_err), 32'(m_mis));
    endtask

    // Drive one cycle of control, advance the model by the fetch rules, check after the edge
    task automatic step(input string tag, input logic s, input logic r, input word_t t);
        word_t cur;
        bus.stall           = s;
        bus.redirect        = r;
        bus.redirect_target = t;
        cur = m_pc;
        if (r) begin
            m_pc    = t - (t % 4);
            m_instr = 32'h0;
            m_valid = 1'b0;
            if ((t % 4) != 0) m_mis = 1'b1;
        end else if (!s) begin
            m_ipc  = cur;
            m_ipc4 = cur + 32'd4;
            if ((cur / 4) < 64) begin
                m_instr = mem[cur / 4];
                m_valid = 1'b1;
            end else begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end
            m_pc = cur + 32'd4;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        foreach (mem[i]) mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'hAC0A_0000;
        m_reset();

        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Straight-line fetch of words 0..3
        for (int i = 0; i < 4; i++) step($sformatf("seq%0d", i), 1'b0, 1'b0, 32'h0);

        // Restart, fetch two words, stall at PC=8
        rst = 1'b1;
        #1;
        m_reset();
        check_all("rst2");
        rst = 1'b0;
        step("s_a", 1'b0, 1'b0, 32'h0);
        step("s_b", 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), 1'b1, 1'b0, 32'h0);
        step("unstall", 1'b0, 1'b0, 32'h0);

        // Redirect beats stall at PC=12
        step("redir40", 1'b1, 1'b1, 32'h40);
        step("w16", 1'b0, 1'b0, 32'h0);

        // Misaligned target sets the sticky flag
        step("mis22", 1'b0, 1'b1, 32'h22);
        for (int i = 0; i < 3; i++) step($sformatf("mis_run%0d", i), 1'b0, 1'b0, 32'h0);

        // Top of memory and beyond
        step("redirFC", 1'b0, 1'b1, 32'hFC);
        for (int i = 0; i < 3; i++) step($sformatf("edge%0d", i), 1'b0, 1'b0, 32'h0);

        // PC wrap at 2^32
        step("redirTop", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap0", 1'b0, 1'b0, 32'h0);
        step("wrap1", 1'b0, 1'b0, 32'h0);

        // Async reset in the middle of a redirect cycle
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h80;
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_all("arst");
        #1;
        rst          = 1'b0;
        bus.redirect = 1'b0;
        step("post_arst0", 1'b0, 1'b0, 32'h0);
        step("post_arst1", 1'b0, 1'b0, 32'h0);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            logic  s, r;
            word_t t;
            r = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = 32'($urandom_range(0, 32'h120));
            step($sformatf("rnd%0d", i), s, r, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Fetch stage of the pipelined MIPS core. It sits directly upstream of the instruction memory file and owns the program counter (PC). It drives the word address into the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register and handles stall, flush and branch/jump redirects from later stages.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
IMEM_DEPTH, 64, number of 32-bit words in instruction memory
NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
Clk  input  1  single clock; all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
Stall  input  1  hazard unit hold: freeze PC and IF/ID
Redirect  input  1  taken branch/jump from a later stage
Redirect_Target  input  32  byte address of redirect target
Imem_Addr  output  32  word index to instruction memory, {2'b00, PC[31:2]}
Imem_Data  input  32  instruction word from memory, same-cycle combinational
Fetch_PC  output  32  current PC (byte address)
IF_ID_Instr  output  32  registered instruction
IF_ID_PC  output  32  registered byte address of IF_ID_Instr
IF_ID_PC4  output  32  registered IF_ID_PC + 4
IF_ID_Valid  output  1  1 = IF_ID_Instr is a real instruction
Range_Err  output  1  combinational: PC[31:2] >= IMEM_DEPTH
Misalign_Err  output  1  sticky: a redirect target had nonzero bits [1:0]

Behaviour:
- Reset (async assert, any time, including mid-redirect or mid-stall):
  - PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PC=0, IF_ID_PC4=0, IF_ID_Valid=0, Misalign_Err=0.
  - Cleared only by Rst.
- Imem_Addr and Fetch_PC are combinational from the PC register. Memory read latency is 0 cycles, so the instruction is captured at the next edge and the fetch-to-IF/ID latency is 1 cycle.
- Each edge is resolved by priority Redirect > Stall > normal:
  - Redirect=1:
    - PC <= Redirect_Target & ~32'h3.
    - IF/ID flushed: Instr=NOP_INSTR, Valid=0, PC/PC4 unchanged.
    - Stall is ignored that cycle.
    - If Redirect_Target[1:0]!=0, set Misalign_Err.
  - Stall=1, Redirect=0: PC and all IF/ID fields hold their values.
  - Normal, in range:
    - PC <= PC+4, wrapping mod 2^32 (0xFFFF_FFFC -> 0).
    - IF_ID_Instr <= Imem_Data, IF_ID_PC <= PC, IF_ID_PC4 <= PC+4 (same wrap), Valid <= 1.
  - Normal with Range_Err=1:
    - PC still advances.
    - IF_ID_Instr <= NOP_INSTR, Valid <= 0, IF_ID_PC/PC4 still loaded.
    - Memory output is not trusted out of range.
- Valid=0 bubbles are treated as NOPs downstream; no ready/valid back-pressure beyond Stall.
- First edge after reset release fetches RESET_PC.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR
  - RESET_PC default
  - XLEN=32
  - IMEM_DEPTH
- One natural sub-module, if_id_pipe_reg:
  - Holds Instr/PC/PC4/Valid.
  - Inputs: load, flush, hold.
  - Async Rst.
  - Reused pattern for later ID/EX registers.
- PC register and next-PC mux stay in the top module.

Test Plan:
1. Reset, release, memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000 -> IF_ID_Instr follows that sequence on edges 1-4 with IF_ID_PC 0,4,8,12, IF_ID_PC4 4,8,12,16, Valid=1, Imem_Addr 0,1,2,3,4.
2. Stall high for 3 cycles at PC=8 -> Fetch_PC stays 8, IF_ID_Instr stays word1 with IF_ID_PC=4. After release, word2 is captured at the next edge.
3. Redirect=1 with Redirect_Target=0x40 at PC=12 while Stall=1 -> next edge PC=0x40, Valid=0, Instr=0. The following edge captures word 16 with IF_ID_PC=0x40.
4. Redirect_Target=0x0000_0022 -> PC=0x20, Misalign_Err=1. It stays 1 through further fetches until Rst.
5. Redirect to 0xFC (word 63), then run -> word 63 fetched valid. PC=0x100 gives Range_Err=1, and the next capture is Valid=0 with NOP_INSTR.
6. Assert Rst asynchronously mid-cycle during a redirect, with Redirect_Target=0x80 -> outputs go to reset values immediately, without waiting for an edge. After release, fetch restarts at RESET_PC, not 0x80.
